// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding, load-use/multi-cycle hazard control and mul/div scoreboard.
// Optional HAZARD_PERF_EN adds free-running stall/flush event counters.
module forward_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int MC_DEPTH = 2,
    localparam int AW      = $clog2(NREG),
    localparam int CW      = $clog2(MC_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_d,
    input  logic [AW-1:0]   rs2_d,
    input  logic [AW-1:0]   rd_d,
    input  logic            mc_op_d,
    input  logic [AW-1:0]   rs1_e,
    input  logic [AW-1:0]   rs2_e,
    input  logic [AW-1:0]   rd_e,
    input  logic            memread_e,
    input  logic            mc_issue_e,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] immext_e,
    input  logic            alusrc_e,
    input  logic [AW-1:0]   rd_m,
    input  logic            regwrite_m,
    input  logic [XLEN-1:0] aluresult_m,
    input  logic [AW-1:0]   rd_w,
    input  logic            regwrite_w,
    input  logic [XLEN-1:0] result_w,
    input  logic            mc_wb,
    input  logic [AW-1:0]   rd_mc,
    output logic [XLEN-1:0] srca_e,
    output logic [XLEN-1:0] srcb_e,
    output logic [XLEN-1:0] writedata_e,
    output logic [1:0]      forwarda_e,
    output logic [1:0]      forwardb_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            sb_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     perf_lw_cnt,
    output logic [31:0]     perf_sb_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sb_err_q, sb_err_d;
    logic            lw_haz, raw_haz, waw_haz, full_haz, stall;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rdm,
                                           input logic          wm,
                                           input logic [AW-1:0] rdw,
                                           input logic          ww);
        if (wm && rdm != '0 && rdm == rs)
            return 2'b10;
        else if (ww && rdw != '0 && rdw == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] m,
                                                input logic [XLEN-1:0] w);
        case (sel)
            2'b00:   return rf;
            2'b10:   return m;
            2'b01:   return w;
            default: return '0;
        endcase
    endfunction

    assign forwarda_e  = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
    assign forwardb_e  = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
    assign srca_e      = fwd_mux(forwarda_e, rd1_e, aluresult_m, result_w);
    assign writedata_e = fwd_mux(forwardb_e, rd2_e, aluresult_m, result_w);
    assign srcb_e      = alusrc_e ? immext_e : writedata_e;

    // An op issuing this cycle counts as pending for the instruction behind it.
    function automatic logic src_pending(input logic [AW-1:0] rs);
        return (rs != '0) && (busy_q[rs] || (mc_issue_e && rs == rd_e));
    endfunction

    assign lw_haz   = memread_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign raw_haz  = src_pending(rs1_d) || src_pending(rs2_d);
    assign waw_haz  = mc_op_d && src_pending(rd_d);
    assign full_haz = mc_op_d && ((int'(cnt_q) + int'(mc_issue_e)) >= MC_DEPTH);
    assign stall    = lw_haz || raw_haz || waw_haz || full_haz;

    assign stall_f = stall && !pcsrc_e;
    assign stall_d = stall && !pcsrc_e;
    assign flush_e = stall || pcsrc_e;
    assign flush_d = pcsrc_e;
    assign sb_err  = sb_err_q;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (mc_wb)
            busy_d[rd_mc] = 1'b0;
        if (mc_issue_e && rd_e != '0)
            busy_d[rd_e] = 1'b1;
        busy_d[0] = 1'b0;
        if (mc_wb && cnt_q == '0)
            sb_err_d = 1'b1;
        if (mc_issue_e && !mc_wb)
            cnt_d = cnt_q + CW'(1);
        else if (!mc_issue_e && mc_wb && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lw_q, perf_sb_q, perf_fl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lw_q <= '0;
            perf_sb_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (lw_haz && !pcsrc_e)
                perf_lw_q <= perf_lw_q + 32'd1;
            if ((raw_haz || waw_haz || full_haz) && !lw_haz && !pcsrc_e)
                perf_sb_q <= perf_sb_q + 32'd1;
            if (pcsrc_e)
                perf_fl_q <= perf_fl_q + 32'd1;
        end
    end

    assign perf_lw_cnt    = perf_lw_q;
    assign perf_sb_cnt    = perf_sb_q;
    assign perf_flush_cnt = perf_fl_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench for forward_hazard_unit (default build, MC_DEPTH = 2).
module tb_forward_hazard_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, rd_mc;
    logic            mc_op_d, memread_e, mc_issue_e, pcsrc_e, alusrc_e;
    logic            regwrite_m, regwrite_w, mc_wb;
    logic [XLEN-1:0] rd1_e, rd2_e, immext_e, aluresult_m, result_w;
    logic [XLEN-1:0] srca_e, srcb_e, writedata_e;
    logic [1:0]      forwarda_e, forwardb_e;
    logic            stall_f, stall_d, flush_d, flush_e, sb_err;
`ifdef HAZARD_PERF_EN
    logic [31:0]     perf_lw_cnt, perf_sb_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.XLEN(32), .NREG(32), .MC_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .mc_op_d(mc_op_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .memread_e(memread_e), .mc_issue_e(mc_issue_e), .pcsrc_e(pcsrc_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e), .alusrc_e(alusrc_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .aluresult_m(aluresult_m),
        .rd_w(rd_w), .regwrite_w(regwrite_w), .result_w(result_w),
        .mc_wb(mc_wb), .rd_mc(rd_mc),
        .srca_e(srca_e), .srcb_e(srcb_e), .writedata_e(writedata_e),
        .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .sb_err(sb_err)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lw_cnt(perf_lw_cnt), .perf_sb_cnt(perf_sb_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // stall_f, stall_d, flush_d, flush_e packed as 4 bits
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, stall_f, stall_d, flush_d, flush_e}, {28'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, rd_mc} = '0;
        {mc_op_d, memread_e, mc_issue_e, pcsrc_e, alusrc_e} = '0;
        {regwrite_m, regwrite_w, mc_wb} = '0;
        rd1_e = 32'h11; rd2_e = 32'h22; immext_e = 32'hCC;
        aluresult_m = 32'hAA; result_w = 32'hBB;
        #2;
        check("rst_sberr", {31'd0, sb_err}, 32'd0);
        check_ctl("rst_ctl", 4'b0000);
        check("rst_fwda", {30'd0, forwarda_e}, 32'd0);
        check("rst_srca", srca_e, 32'h11);
        tick;
        reset = 1'b0;

        // forwarding: MEM priority, then WB, then regfile
        rs1_e = 5; rs2_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
        #1;
        check("fwda_mem", {30'd0, forwarda_e}, 32'd2);
        check("srca_mem", srca_e, 32'hAA);
        check("wd_mem", writedata_e, 32'hAA);
        rd_m = 0;
        #1;
        check("fwda_wb", {30'd0, forwarda_e}, 32'd1);
        check("srca_wb", srca_e, 32'hBB);
        check("fwdb_wb", {30'd0, forwardb_e}, 32'd1);
        check("srcb_reg", srcb_e, 32'hBB);
        alusrc_e = 1;
        #1;
        check("srcb_imm", srcb_e, 32'hCC);
        check("wd_imm", writedata_e, 32'hBB);
        regwrite_w = 0; alusrc_e = 0;
        #1;
        check("srca_rf", srca_e, 32'h11);
        check("srcb_rf", srcb_e, 32'h22);
        rd_w = 0; rd_m = 5; regwrite_m = 0;
        #1;
        check("fwda_nowr", {30'd0, forwarda_e}, 32'd0);
        rs1_e = 0; rs2_e = 0; rd_m = 0;

        // load-use
        memread_e = 1; rd_e = 7; rs2_d = 7;
        #1;
        check_ctl("lw_haz", 4'b1101);
        rd_e = 0; rs2_d = 0;
        #1;
        check_ctl("lw_x0", 4'b0000);
        // branch overrides load-use
        rd_e = 7; rs2_d = 7; pcsrc_e = 1;
        #1;
        check_ctl("lw_branch", 4'b0011);
        memread_e = 0; pcsrc_e = 0; rd_e = 0; rs2_d = 0;
        tick;

        // multi-cycle RAW on x9
        mc_issue_e = 1; rd_e = 9; rs1_d = 9;
        #1;
        check_ctl("raw_issue", 4'b1101);
        tick;
        mc_issue_e = 0; rd_e = 0;
        #1;
        check_ctl("raw_busy", 4'b1101);
        tick;
        check_ctl("raw_busy2", 4'b1101);
        mc_wb = 1; rd_mc = 9;
        #1;
        check_ctl("raw_wbcyc", 4'b1101);
        tick;
        mc_wb = 0; rd_mc = 0;
        #1;
        check_ctl("raw_release", 4'b0000);
        rs1_d = 0;

        // capacity: two ops in flight fill MC_DEPTH = 2
        mc_issue_e = 1; rd_e = 3; mc_op_d = 1; rd_d = 4;
        #1;
        check_ctl("full_one", 4'b0000);
        tick;
        rd_e = 4; rd_d = 5;
        #1;
        check_ctl("full_issue2", 4'b1101);
        tick;
        mc_issue_e = 0; rd_e = 0;
        #1;
        check_ctl("full_third", 4'b1101);
        mc_op_d = 0;
        #1;
        check_ctl("full_noop", 4'b0000);
        rd_d = 0;
        mc_op_d = 0; rd_d = 4;
        // simultaneous issue and retire keeps cnt at 2
        mc_issue_e = 1; rd_e = 6; mc_wb = 1; rd_mc = 3; rd_d = 0;
        tick;
        mc_issue_e = 0; rd_e = 0; mc_wb = 0; rd_mc = 0;
        mc_op_d = 1; rd_d = 5;
        #1;
        check_ctl("cnt_same", 4'b1101);
        mc_op_d = 0; rd_d = 0; rs1_d = 3;
        #1;
        check_ctl("busy3_clr", 4'b0000);
        rs1_d = 6;
        #1;
        check_ctl("busy6_set", 4'b1101);
        rs1_d = 0;
        // waw against busy x4
        mc_op_d = 1; rd_d = 4;
        #1;
        check_ctl("waw_busy", 4'b1101);
        mc_op_d = 0; rd_d = 0;
        mc_wb = 1; rd_mc = 4;
        tick;
        rd_mc = 6;
        tick;
        mc_wb = 0; rd_mc = 0;
        mc_op_d = 1; rd_d = 5;
        #1;
        check_ctl("drained", 4'b0000);
        check("sberr_clean", {31'd0, sb_err}, 32'd0);
        mc_op_d = 0; rd_d = 0;

        // retire with nothing in flight
        mc_wb = 1; rd_mc = 1;
        tick;
        mc_wb = 0; rd_mc = 0;
        check("sberr_set", {31'd0, sb_err}, 32'd1);
        tick;
        check("sberr_hold", {31'd0, sb_err}, 32'd1);

        // fill scoreboard, then async reset mid-cycle
        mc_issue_e = 1; rd_e = 12;
        tick;
        rd_e = 13;
        tick;
        mc_issue_e = 0; rd_e = 0; rs1_d = 12;
        #1;
        check_ctl("pre_rst", 4'b1101);
        #1;
        reset = 1'b1;
        #1;
        check_ctl("rst_busy", 4'b0000);
        check("rst_sberr2", {31'd0, sb_err}, 32'd0);
        rs1_d = 0; rs2_d = 13; mc_op_d = 1; rd_d = 5;
        #1;
        check_ctl("rst_cnt", 4'b0000);
        reset = 1'b0;
        tick;
        check_ctl("post_rst", 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1);
    end

endmodule
